// File: rtl/mem_wb_stage_if.sv
// MEM -> WB beat bundle with a valid/ready handshake.
// The MEM stage drives the master side; write-back is the slave.
interface mem_wb_stage_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int REG_WIDTH  = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_pc;
    logic [INST_WIDTH-1:0] in_inst;
    logic [DATA_WIDTH-1:0] in_rw_data;
    logic [REG_WIDTH-1:0]  in_rw_addr;
    logic                  in_rw_en;

    modport master (
        output in_valid,
        output in_pc,
        output in_inst,
        output in_rw_data,
        output in_rw_addr,
        output in_rw_en,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_pc,
        input  in_inst,
        input  in_rw_data,
        input  in_rw_addr,
        input  in_rw_en,
        output in_ready
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Write-back stage: 2-entry elastic buffer (head + skid) retiring
// in order into the regfile, commit port and retired counter.
module mem_wb_stage #(
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int REG_WIDTH  = 5,
    parameter int CNT_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mem_wb_stage_if.slave         mem,
    input  logic                  flush,
    input  logic                  stall,
    output logic                  rf_we,
    output logic [REG_WIDTH-1:0]  rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
    output logic                  commit_valid,
    output logic [ADDR_WIDTH-1:0] commit_pc,
    output logic [INST_WIDTH-1:0] commit_inst,
    output logic                  fwd0_valid,
    output logic [REG_WIDTH-1:0]  fwd0_addr,
    output logic [DATA_WIDTH-1:0] fwd0_data,
    output logic                  fwd1_valid,
    output logic [REG_WIDTH-1:0]  fwd1_addr,
    output logic [DATA_WIDTH-1:0] fwd1_data,
    output logic [CNT_WIDTH-1:0]  retired_cnt
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [INST_WIDTH-1:0] inst;
        logic [DATA_WIDTH-1:0] data;
        logic [REG_WIDTH-1:0]  addr;
        logic                  en;
    } entry_t;

    entry_t               head_q, head_d;
    entry_t               skid_q, skid_d;
    logic                 head_v_q, head_v_d;
    logic                 skid_v_q, skid_v_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    entry_t beat;
    logic   retire;
    logic   accept;
    logic   head_free;

    assign beat.pc   = mem.in_pc;
    assign beat.inst = mem.in_inst;
    assign beat.data = mem.in_rw_data;
    assign beat.addr = mem.in_rw_addr;
    assign beat.en   = mem.in_rw_en;

    // Ready comes from state only, so MEM never sees a comb loop.
    assign mem.in_ready = !skid_v_q;

    assign retire    = head_v_q && !stall;
    assign accept    = mem.in_valid && !skid_v_q && !flush;
    assign head_free = !head_v_q || retire;

    always_comb begin
        head_d   = head_q;
        skid_d   = skid_q;
        head_v_d = head_v_q;
        skid_v_d = skid_v_q;
        cnt_d    = cnt_q + {{(CNT_WIDTH-1){1'b0}}, retire};
        if (flush) begin
            head_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (head_free) begin
            // Skid full implies no accept this cycle.
            if (skid_v_q) begin
                head_d   = skid_q;
                head_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else if (accept) begin
                head_d   = beat;
                head_v_d = 1'b1;
            end else begin
                head_v_d = 1'b0;
            end
        end else if (accept) begin
            skid_d   = beat;
            skid_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            skid_q   <= '0;
            head_v_q <= 1'b0;
            skid_v_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            head_q   <= head_d;
            skid_q   <= skid_d;
            head_v_q <= head_v_d;
            skid_v_q <= skid_v_d;
            cnt_q    <= cnt_d;
        end
    end

    assign commit_valid = retire;
    assign commit_pc    = head_v_q ? head_q.pc : '0;
    assign commit_inst  = head_v_q ? head_q.inst : '0;

    assign rf_we    = retire && head_q.en && (head_q.addr != '0);
    assign rf_waddr = head_v_q ? head_q.addr : '0;
    assign rf_wdata = head_v_q ? head_q.data : '0;

    assign fwd0_valid = head_v_q && head_q.en && (head_q.addr != '0);
    assign fwd0_addr  = fwd0_valid ? head_q.addr : '0;
    assign fwd0_data  = fwd0_valid ? head_q.data : '0;

    assign fwd1_valid = skid_v_q && skid_q.en && (skid_q.addr != '0);
    assign fwd1_addr  = fwd1_valid ? skid_q.addr : '0;
    assign fwd1_data  = fwd1_valid ? skid_q.data : '0;

    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed bench for mem_wb_stage (8-bit counter build so that
// counter wrap is reachable by retiring instructions).
module tb_mem_wb_stage;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          stall;
    logic          rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic          commit_valid;
    logic [31:0]   commit_pc;
    logic [31:0]   commit_inst;
    logic          fwd0_valid;
    logic [4:0]    fwd0_addr;
    logic [31:0]   fwd0_data;
    logic          fwd1_valid;
    logic [4:0]    fwd1_addr;
    logic [31:0]   fwd1_data;
    logic [CW-1:0] retired_cnt;

    int total = 0;
    int bad   = 0;

    mem_wb_stage_if #(
        .ADDR_WIDTH(32), .INST_WIDTH(32),
        .DATA_WIDTH(32), .REG_WIDTH(5)
    ) bus ();

    mem_wb_stage #(
        .ADDR_WIDTH(32), .INST_WIDTH(32),
        .DATA_WIDTH(32), .REG_WIDTH(5),
        .CNT_WIDTH(CW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem          (bus.slave),
        .flush        (flush),
        .stall        (stall),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_inst  (commit_inst),
        .fwd0_valid   (fwd0_valid),
        .fwd0_addr    (fwd0_addr),
        .fwd0_data    (fwd0_data),
        .fwd1_valid   (fwd1_valid),
        .fwd1_addr    (fwd1_addr),
        .fwd1_data    (fwd1_data),
        .retired_cnt  (retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge.
    task automatic drive(input logic        v,
                         input logic [31:0] pc,
                         input logic [31:0] data,
                         input logic [4:0]  addr,
                         input logic        en,
                         input logic        fl,
                         input logic        st);
        @(negedge clk);
        bus.in_valid   = v;
        bus.in_pc      = pc;
        bus.in_inst    = pc ^ 32'h0000_0013;
        bus.in_rw_data = data;
        bus.in_rw_addr = addr;
        bus.in_rw_en   = en;
        flush          = fl;
        stall          = st;
        #1;
    endtask

    task automatic idle(input logic st);
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, st);
    endtask

    task automatic chk_commit(input string tag,
                              input logic [31:0] pc,
                              input logic [4:0] addr,
                              input logic [31:0] data);
        chk({tag, "_cv"}, 64'(commit_valid), 64'd1);
        chk({tag, "_pc"}, 64'(commit_pc), 64'(pc));
        chk({tag, "_inst"}, 64'(commit_inst),
            64'(pc ^ 32'h0000_0013));
        chk({tag, "_we"}, 64'(rf_we), 64'd1);
        chk({tag, "_wa"}, 64'(rf_waddr), 64'(addr));
        chk({tag, "_wd"}, 64'(rf_wdata), 64'(data));
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_pc      = '0;
        bus.in_inst    = '0;
        bus.in_rw_data = '0;
        bus.in_rw_addr = '0;
        bus.in_rw_en   = 1'b0;
        flush          = 1'b0;
        stall          = 1'b0;

        // Reset values
        #12;
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_cv", 64'(commit_valid), 64'd0);
        chk("rst_we", 64'(rf_we), 64'd0);
        chk("rst_cnt", 64'(retired_cnt), 64'd0);
        chk("rst_f0v", 64'(fwd0_valid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back, one cycle latency
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 32'h1c00_0000 + 32'(4 * k),
                  32'hA + 32'(k), 5'(k + 1), 1'b1, 1'b0, 1'b0);
            chk("b2b_ready", 64'(bus.in_ready), 64'd1);
            if (k == 0)
                chk("b2b_cv0", 64'(commit_valid), 64'd0);
            else
                chk_commit("b2b", 32'h1c00_0000 + 32'(4 * (k - 1)),
                           5'(k), 32'hA + 32'(k - 1));
        end
        idle(1'b0);
        chk_commit("b2b_last", 32'h1c00_000c, 5'd4, 32'hD);
        idle(1'b0);
        chk("b2b_idle_cv", 64'(commit_valid), 64'd0);
        chk("b2b_cnt", 64'(retired_cnt), 64'd4);

        // r0 write is committed but not written or forwarded
        drive(1'b1, 32'h1c00_0010, 32'hFFFF_FFFF, 5'd0,
              1'b1, 1'b0, 1'b0);
        idle(1'b0);
        chk("r0_cv", 64'(commit_valid), 64'd1);
        chk("r0_pc", 64'(commit_pc), 64'h1c00_0010);
        chk("r0_we", 64'(rf_we), 64'd0);
        chk("r0_f0v", 64'(fwd0_valid), 64'd0);
        chk("r0_f0d", 64'(fwd0_data), 64'd0);
        idle(1'b0);
        chk("r0_cnt", 64'(retired_cnt), 64'd5);

        // Stall fills head then skid; third beat waits
        drive(1'b1, 32'h1c00_0100, 32'h100, 5'd6, 1'b1, 1'b0, 1'b1);
        chk("st_rdy0", 64'(bus.in_ready), 64'd1);
        drive(1'b1, 32'h1c00_0104, 32'h104, 5'd7, 1'b1, 1'b0, 1'b1);
        chk("st_rdy1", 64'(bus.in_ready), 64'd1);
        chk("st_cv", 64'(commit_valid), 64'd0);
        chk("st_f0v", 64'(fwd0_valid), 64'd1);
        chk("st_f0a", 64'(fwd0_addr), 64'd6);
        drive(1'b1, 32'h1c00_0108, 32'h108, 5'd8, 1'b1, 1'b0, 1'b1);
        chk("st_rdy2", 64'(bus.in_ready), 64'd0);
        chk("st_f1v", 64'(fwd1_valid), 64'd1);
        chk("st_f1a", 64'(fwd1_addr), 64'd7);
        drive(1'b1, 32'h1c00_0108, 32'h108, 5'd8, 1'b1, 1'b0, 1'b1);
        chk("st_hold_rdy", 64'(bus.in_ready), 64'd0);
        chk("st_hold_pc", 64'(commit_pc), 64'h1c00_0100);
        // Release stall, third beat stays offered until taken
        drive(1'b1, 32'h1c00_0108, 32'h108, 5'd8, 1'b1, 1'b0, 1'b0);
        chk("rel_rdy", 64'(bus.in_ready), 64'd0);
        chk_commit("rel0", 32'h1c00_0100, 5'd6, 32'h100);
        drive(1'b1, 32'h1c00_0108, 32'h108, 5'd8, 1'b1, 1'b0, 1'b0);
        chk("rel_rdy1", 64'(bus.in_ready), 64'd1);
        chk_commit("rel1", 32'h1c00_0104, 5'd7, 32'h104);
        idle(1'b0);
        chk_commit("rel2", 32'h1c00_0108, 5'd8, 32'h108);
        idle(1'b0);
        chk("rel_cv", 64'(commit_valid), 64'd0);
        chk("rel_cnt", 64'(retired_cnt), 64'd8);

        // Forwarding: same rd in both entries
        drive(1'b1, 32'h1c00_0200, 32'h11, 5'd5, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 32'h1c00_0204, 32'h22, 5'd5, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        chk("fw_f0v", 64'(fwd0_valid), 64'd1);
        chk("fw_f0d", 64'(fwd0_data), 64'h11);
        chk("fw_f1v", 64'(fwd1_valid), 64'd1);
        chk("fw_f1a", 64'(fwd1_addr), 64'd5);
        chk("fw_f1d", 64'(fwd1_data), 64'h22);
        chk("fw_rdy", 64'(bus.in_ready), 64'd0);

        // Flush with full buffer: head still retires
        drive(1'b1, 32'h1c00_0300, 32'h33, 5'd9, 1'b1, 1'b1, 1'b0);
        chk_commit("fl", 32'h1c00_0200, 5'd5, 32'h11);
        idle(1'b0);
        chk("fl_cv", 64'(commit_valid), 64'd0);
        chk("fl_pc", 64'(commit_pc), 64'd0);
        chk("fl_f0v", 64'(fwd0_valid), 64'd0);
        chk("fl_f1v", 64'(fwd1_valid), 64'd0);
        chk("fl_rdy", 64'(bus.in_ready), 64'd1);
        chk("fl_cnt", 64'(retired_cnt), 64'd9);

        // Counter wrap: 9 + 246 = 0xFF, then one more -> 0
        for (int i = 0; i < 246; i++)
            drive(1'b1, 32'h1c00_1000 + 32'(4 * i), 32'(i),
                  5'd10, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("wr_ff", 64'(retired_cnt), 64'hFF);
        drive(1'b1, 32'h1c00_2000, 32'h44, 5'd11, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("wr_zero", 64'(retired_cnt), 64'd0);

        // Async reset mid-cycle drops an in-flight beat
        drive(1'b1, 32'h1c00_3000, 32'h55, 5'd12, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        chk("ar_pre_f0v", 64'(fwd0_valid), 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_f0v", 64'(fwd0_valid), 64'd0);
        chk("ar_rdy", 64'(bus.in_ready), 64'd1);
        chk("ar_pc", 64'(commit_pc), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Receiving end of the MEM-stage output bundle (pc, inst, rw_data, rw_addr, rw_en).
- Registers each beat into a 2-entry elastic buffer, then retires it in order as the write-back stage.
- Retirement drives the register-file write port and the commit/trace port, and increments a retired-instruction counter.
- Also presents bypass data to the decode/execute forwarding logic.

Parameters:
- ADDR_WIDTH, 32, width of pc
- INST_WIDTH, 32, width of inst
- DATA_WIDTH, 32, width of rw_data
- REG_WIDTH, 5, width of rw_addr
- CNT_WIDTH, 64, width of retired-instruction counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  MEM stage presents a beat
- in_ready  out  1  block can accept a beat
- in_pc  in  ADDR_WIDTH  beat pc
- in_inst  in  INST_WIDTH  beat instruction word
- in_rw_data  in  DATA_WIDTH  write-back data
- in_rw_addr  in  REG_WIDTH  destination register
- in_rw_en  in  1  destination write enable
- flush  in  1  discard all buffered and incoming beats
- stall  in  1  hold retirement (debug halt / regfile busy)
- rf_we  out  1  register-file write enable
- rf_waddr  out  REG_WIDTH  register-file write address
- rf_wdata  out  DATA_WIDTH  register-file write data
- commit_valid  out  1  one instruction retires this cycle
- commit_pc  out  ADDR_WIDTH  retiring pc
- commit_inst  out  INST_WIDTH  retiring instruction
- fwd0_valid, fwd0_addr, fwd0_data  out  1/REG_WIDTH/DATA_WIDTH  bypass from head (older) entry
- fwd1_valid, fwd1_addr, fwd1_data  out  1/REG_WIDTH/DATA_WIDTH  bypass from skid (younger) entry
- retired_cnt  out  CNT_WIDTH  instructions retired since reset

Behaviour:
- Reset is asynchronous and active-low. While rst_n=0:
  - head_v=0, skid_v=0, retired_cnt=0.
  - All outputs are 0 except in_ready, which is 1.
- Accept: a beat is accepted on a rising edge when in_valid && in_ready && !flush.
- Retire: retire = head_v && !stall (combinational).
  - commit_valid = retire; commit_pc and commit_inst come from the head entry.
  - commit_pc and commit_inst read 0 when head_v=0.
- Register-file write:
  - rf_we = retire && head.rw_en && head.rw_addr != 0. Writes to r0 are suppressed, but the instruction still commits.
  - rf_waddr and rf_wdata come from the head entry.
- Ready: in_ready = !skid_v. It is registered-only and never depends on in_valid or stall.
- Latency: an accepted beat reaches head and can retire on the next cycle. There is one cycle of minimum latency.
- Per-edge update, with flush taking priority:
  - flush=1: head_v and skid_v become 0, and any input beat is dropped. An instruction retiring in the same cycle as flush still commits and writes.
  - Otherwise, after retire pops head, the incoming beat fills the oldest empty slot in order: head first, then skid.
  - head empty or retired, skid empty, accept: beat goes to head.
  - head retired, skid full: skid moves to head. in_ready was 0, so no accept is possible.
  - head held (stall or not retired), skid empty, accept: beat goes to skid.
  - Order is strictly FIFO; no beat is ever lost or duplicated without a flush.
- stall=1 with both entries full: in_ready=0 and contents hold indefinitely.
- Forwarding:
  - fwd0_valid = head_v && head.rw_en && head.rw_addr != 0.
  - fwd1_valid is the same condition on the skid entry.
  - Consumers give fwd1 priority over fwd0 on an address match.
  - When a fwd*_valid is 0, its address and data outputs read 0.
- retired_cnt increments by 1 on each retire. It wraps modulo 2^CNT_WIDTH and is unaffected by flush.
- Reset asserted mid-operation clears all state immediately; in-flight beats are lost.

Test Plan:
- Reset: rst_n low, then high -> in_ready=1, commit_valid=0, rf_we=0, retired_cnt=0.
- Back-to-back: 4 beats (pc 0x1c000000..0x1c00000c, rw_addr 1..4, data 0xA..0xD), stall=0 -> commits in order one cycle after each accept, rf_we each cycle, retired_cnt=4.
- r0 suppression: beat with rw_en=1, rw_addr=0, data 0xFFFFFFFF -> commit_valid=1, rf_we=0, fwd0_valid=0.
- Stall and skid: hold stall=1 and push 3 beats -> first two are accepted, in_ready=0 on the third. Release stall -> three commits in order over three cycles, with no loss.
- Flush: both entries full, assert flush for one cycle with in_valid=1 -> the retiring head (if stall=0) commits, the other entries and the incoming beat are dropped, and head_v=0 next cycle.
- Forward priority and wrap:
  - head writes r5=0x11 and skid writes r5=0x22 -> fwd0_data=0x11, fwd1_data=0x22.
  - Force retired_cnt to all ones (CNT_WIDTH=8 build: 0xFF), then retire one -> retired_cnt=0.
